// File: rtl/memoria_pkg.sv
// memoria_pkg
// Shared definitions for the parametrised dual-port memory:
//   state_t  - initialisation FSM encoding (ST_CLEAR, ST_RUN)
//   RW_*     - values of the per-port rw request bit
//   RDW_*    - cross-port read-during-write modes
package memoria_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/memoria_dp_param_if.sv
// memoria_dp_param_if
// Request/response bundle for the two ports of memoria_dp_param plus the
// shared status flags.
//   en*/rw*/Addr*/DataIn*  requester -> memory
//   DataOut*/valid*        memory -> requester
//   ready/collision        memory -> requester
// master: the requester side, slave: the memory side.
interface memoria_dp_param_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  enA;
  logic                  rwA;
  logic [ADDR_WIDTH-1:0] AddrA;
  logic [DATA_WIDTH-1:0] DataInA;
  logic [DATA_WIDTH-1:0] DataOutA;
  logic                  validA;

  logic                  enB;
  logic                  rwB;
  logic [ADDR_WIDTH-1:0] AddrB;
  logic [DATA_WIDTH-1:0] DataInB;
  logic [DATA_WIDTH-1:0] DataOutB;
  logic                  validB;

  logic                  ready;
  logic                  collision;

  modport master (
    output enA, rwA, AddrA, DataInA,
    output enB, rwB, AddrB, DataInB,
    input  DataOutA, validA, DataOutB, validB,
    input  ready, collision
  );

  modport slave (
    input  enA, rwA, AddrA, DataInA,
    input  enB, rwB, AddrB, DataInB,
    output DataOutA, validA, DataOutB, validB,
    output ready, collision
  );
endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe
// LAT-deep read return pipeline for one memory port. A valid/data pair
// enters each cycle; data in a stage only changes when a valid word moves
// into it, so the output holds the last read value between strobes.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   read request strobe and the word read this cycle
//   out_valid, out_data delayed strobe and held read data
module mem_rd_pipe #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LAT-1:0]            valid_q, valid_d;
  logic [LAT-1:0][WIDTH-1:0] data_q, data_d;

  // Stage i loads from stage i-1 only when that stage carries a valid word.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    if (in_valid) data_d[0] = in_data;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/memoria_dp_param.sv
// memoria_dp_param
// Parametrised true dual-port synchronous memory with a self-clearing
// initialisation pass after reset, per-port read-valid strobes, selectable
// cross-port read-during-write behaviour and write-write collision flag.
//   clk      system clock, rising edge
//   reset_L  asynchronous active-low reset
//   bus      memoria_dp_param_if.slave: port A/B requests and read data,
//            ready (initialised) and collision (one-cycle pulse)
module memoria_dp_param
  import memoria_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int READ_LAT   = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                clk,
  input  logic                reset_L,
  memoria_dp_param_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  collision_q, collision_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  run;
  logic                  same_addr;
  logic                  wr_a, wr_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  assign run = (state_q == ST_RUN);

  // Request decode. On a same-address write-write, port A wins and the
  // port B write is dropped. A reader only sees the other port's write data
  // when the new-data read-during-write mode is selected.
  always_comb begin
    same_addr   = (bus.AddrA == bus.AddrB);
    wr_a        = run && bus.enA && (bus.rwA == RW_WRITE);
    wr_b        = run && bus.enB && (bus.rwB == RW_WRITE) && !(wr_a && same_addr);
    rd_a        = run && bus.enA && (bus.rwA == RW_READ);
    rd_b        = run && bus.enB && (bus.rwB == RW_READ);
    collision_d = wr_a && bus.enB && (bus.rwB == RW_WRITE) && same_addr;

    rdata_a = mem_q[bus.AddrA];
    rdata_b = mem_q[bus.AddrB];
    if (RDW_MODE == RDW_NEW) begin
      if (wr_b && same_addr) rdata_a = bus.DataInB;
      if (wr_a && same_addr) rdata_b = bus.DataInA;
    end
  end

  // Initialisation FSM: sweep every address once, then run until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (ADDR_WIDTH+1)'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collision_q <= collision_d;
    end
  end

  // Storage is not reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      if (wr_b) mem_q[bus.AddrB] <= bus.DataInB;
      if (wr_a) mem_q[bus.AddrA] <= bus.DataInA;
    end
  end

  mem_rd_pipe #(.WIDTH(DATA_WIDTH), .LAT(READ_LAT)) u_pipe_a (
    .clk       (clk),
    .rst_n     (reset_L),
    .in_valid  (rd_a),
    .in_data   (rdata_a),
    .out_valid (bus.validA),
    .out_data  (bus.DataOutA)
  );

  mem_rd_pipe #(.WIDTH(DATA_WIDTH), .LAT(READ_LAT)) u_pipe_b (
    .clk       (clk),
    .rst_n     (reset_L),
    .in_valid  (rd_b),
    .in_data   (rdata_b),
    .out_valid (bus.validB),
    .out_data  (bus.DataOutB)
  );

  assign bus.ready     = run;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_memoria_dp_param.sv
// tb_memoria_dp_param
// Drives two instances with identical traffic: dut0 (READ_LAT=1, old-data
// read-during-write) and dut1 (READ_LAT=2, new-data read-during-write).
// A behavioural model (word array, clear countdown, read results scheduled
// by due cycle) predicts ready, collision, valid and DataOut every cycle.
module tb_memoria_dp_param;
  import memoria_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_L;

  always #5 clk = ~clk;

  memoria_dp_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  memoria_dp_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  memoria_dp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .reset_L(reset_L), .bus(bus0)
  );

  memoria_dp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset_L(reset_L), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left;
  int            cyc;
  logic          coll_m;
  logic          sched_v [2][2][4];
  logic [DW-1:0] sched_d [2][2][4];
  logic [DW-1:0] last_d  [2][2];

  function automatic int latOf(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] obsOf(int k, int sel);
    logic [31:0] r;
    r = '0;
    case (sel)
      0: r = (k == 0) ? 32'(bus0.validA)    : 32'(bus1.validA);
      1: r = (k == 0) ? 32'(bus0.DataOutA)  : 32'(bus1.DataOutA);
      2: r = (k == 0) ? 32'(bus0.validB)    : 32'(bus1.validB);
      3: r = (k == 0) ? 32'(bus0.DataOutB)  : 32'(bus1.DataOutB);
      4: r = (k == 0) ? 32'(bus0.ready)     : 32'(bus1.ready);
      default: r = (k == 0) ? 32'(bus0.collision) : 32'(bus1.collision);
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic driveInputs(input logic eA, input logic rA, input logic [AW-1:0] aA, input logic [DW-1:0] dA,
                             input logic eB, input logic rB, input logic [AW-1:0] aB, input logic [DW-1:0] dB);
    bus0.enA = eA; bus0.rwA = rA; bus0.AddrA = aA; bus0.DataInA = dA;
    bus0.enB = eB; bus0.rwB = rB; bus0.AddrB = aB; bus0.DataInB = dB;
    bus1.enA = eA; bus1.rwA = rA; bus1.AddrA = aA; bus1.DataInA = dA;
    bus1.enB = eB; bus1.rwB = rB; bus1.AddrB = aB; bus1.DataInB = dB;
  endtask

  // Compare every output of both instances against the model for this cycle.
  task automatic checkCycle();
    int   slot;
    logic ev;
    slot = cyc % 4;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        ev = sched_v[k][p][slot];
        if (ev) begin
          last_d[k][p]        = sched_d[k][p][slot];
          sched_v[k][p][slot] = 1'b0;
        end
        checkOutput($sformatf("dut%0d_valid%s", k, (p == 0) ? "A" : "B"), obsOf(k, 2*p), 32'(ev));
        checkOutput($sformatf("dut%0d_DataOut%s", k, (p == 0) ? "A" : "B"), obsOf(k, 2*p+1), 32'(last_d[k][p]));
      end
      checkOutput($sformatf("dut%0d_ready", k), obsOf(k, 4), 32'(clear_left == 0));
      checkOutput($sformatf("dut%0d_collision", k), obsOf(k, 5), 32'(coll_m));
    end
  endtask

  // One clock cycle of requests: update the model, clock, then check.
  task automatic applyStimulus(input logic eA, input logic rA, input logic [AW-1:0] aA, input logic [DW-1:0] dA,
                               input logic eB, input logic rB, input logic [AW-1:0] aB, input logic [DW-1:0] dB);
    logic          run, wA, wB, next_coll;
    logic [DW-1:0] v;
    int            slot;
    driveInputs(eA, rA, aA, dA, eB, rB, aB, dB);
    run       = (clear_left == 0);
    wA        = eA && (rA == RW_WRITE);
    wB        = eB && (rB == RW_WRITE);
    next_coll = run && wA && wB && (aA == aB);
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        slot = (cyc + latOf(k)) % 4;
        if (eA && !wA) begin
          v = mem_m[aA];
          if (k == 1 && wB && aB == aA) v = dB;
          sched_v[k][0][slot] = 1'b1;
          sched_d[k][0][slot] = v;
        end
        if (eB && !wB) begin
          v = mem_m[aB];
          if (k == 1 && wA && aA == aB) v = dA;
          sched_v[k][1][slot] = 1'b1;
          sched_d[k][1][slot] = v;
        end
      end
      if (wB && !(wA && aA == aB)) mem_m[aB] = dB;
      if (wA) mem_m[aA] = dA;
    end
    @(posedge clk);
    #2;
    cyc++;
    if (clear_left > 0) clear_left--;
    coll_m = next_coll;
    checkCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic randomCycle();
    logic          eA, rA, eB, rB;
    logic [AW-1:0] aA, aB;
    logic [DW-1:0] dA, dB;
    eA = 1'($urandom_range(0, 1)); rA = 1'($urandom_range(0, 1));
    eB = 1'($urandom_range(0, 1)); rB = 1'($urandom_range(0, 1));
    aA = AW'($urandom_range(0, 7)); aB = AW'($urandom_range(0, 7));
    dA = DW'($urandom_range(0, 15)); dB = DW'($urandom_range(0, 15));
    applyStimulus(eA, rA, aA, dA, eB, rB, aB, dB);
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic doReset();
    driveInputs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    reset_L = 1'b0;
    #1;
    clear_left = DEPTH;
    coll_m     = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        last_d[k][p] = '0;
        for (int s = 0; s < 4; s++) sched_v[k][p][s] = 1'b0;
      end
    checkCycle();
    @(posedge clk);
    @(posedge clk);
    #2;
    checkCycle();
    reset_L = 1'b1;
  endtask

  initial begin
    cyc     = 0;
    reset_L = 1'b1;
    driveInputs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #3;
    doReset();

    // Requests during the clear sweep are ignored; ready rises after 8 cycles
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, RW_WRITE, AW'(i), 4'hF, 1'b1, 1'(i % 2), AW'(7 - i), 4'hE);

    // Every address reads back zero after the sweep
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, RW_READ, AW'(i), '0, 1'b1, RW_READ, AW'(7 - i), '0);
    idleCycle(); idleCycle();

    // Write through A, read through B
    applyStimulus(1'b1, RW_WRITE, 3'd3, 4'hA, 1'b0, RW_READ, '0, '0);
    applyStimulus(1'b0, RW_READ, '0, '0, 1'b1, RW_READ, 3'd3, '0);
    idleCycle(); idleCycle();

    // Write-write collision: A wins
    applyStimulus(1'b1, RW_WRITE, 3'd6, 4'h5, 1'b1, RW_WRITE, 3'd6, 4'h9);
    applyStimulus(1'b1, RW_READ, 3'd6, '0, 1'b1, RW_READ, 3'd6, '0);
    idleCycle(); idleCycle();

    // Read-during-write across ports, both directions
    applyStimulus(1'b1, RW_WRITE, 3'd2, 4'h1, 1'b0, RW_READ, '0, '0);
    applyStimulus(1'b1, RW_WRITE, 3'd2, 4'h7, 1'b1, RW_READ, 3'd2, '0);
    applyStimulus(1'b1, RW_READ, 3'd2, '0, 1'b1, RW_WRITE, 3'd2, 4'hC);
    applyStimulus(1'b0, RW_READ, '0, '0, 1'b1, RW_READ, 3'd2, '0);
    idleCycle(); idleCycle();

    // Back-to-back alternating reads on both ports
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, RW_READ, AW'(i % 2 == 0 ? 3 : 6), '0, 1'b1, RW_READ, AW'(i % 2 == 0 ? 2 : 6), '0);
    idleCycle(); idleCycle();

    // Random traffic
    for (int i = 0; i < 300; i++) randomCycle();

    // Reset while running after writes: contents read back as zero
    applyStimulus(1'b1, RW_WRITE, 3'd1, 4'hB, 1'b1, RW_WRITE, 3'd5, 4'hD);
    doReset();
    for (int i = 0; i < DEPTH; i++) randomCycle();
    applyStimulus(1'b1, RW_READ, 3'd1, '0, 1'b1, RW_READ, 3'd5, '0);
    idleCycle(); idleCycle();

    // Reset partway through the clear sweep restarts the full sweep
    doReset();
    for (int i = 0; i < 4; i++) randomCycle();
    doReset();
    for (int i = 0; i < DEPTH; i++) randomCycle();
    for (int i = 0; i < 200; i++) randomCycle();
    idleCycle(); idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
